abc_input_conditioner: RTL and testbench



---
 rtl/abc_cond_pkg.sv | 8 +
 rtl/debounce_ch.sv | 48 ++++
 rtl/abc_input_conditioner.sv | 36 +++
 tb/tb_abc_input_conditioner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/abc_cond_pkg.sv
// Shared defaults and channel indices for the a/b/c input conditioner.
package abc_cond_pkg;
  localparam int N_CH_DEFAULT   = 3;
  localparam int STABLE_DEFAULT = 4;
  localparam int CH_A = 2;
  localparam int CH_B = 1;
  localparam int CH_C = 0;
endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchroniser, stability-count debouncer and
// registered rise/fall strobes.
module debounce_ch
  import abc_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic fire
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] count;

  // fire marks the edge on which clean takes the synchronised value
  assign fire = (sync2 != clean) && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      count <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= fire & sync2;
      fall  <= fire & ~sync2;
      if (sync2 == clean) begin
        count <= '0;
      end else if (fire) begin
        clean <= sync2;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/abc_input_conditioner.sv
// Conditions raw a/b/c lines into clean, clock-aligned levels plus edge
// strobes for the downstream sequential block.
module abc_input_conditioner
  import abc_cond_pkg::*;
#(
  parameter int N_CH          = N_CH_DEFAULT,
  parameter int STABLE_CYCLES = STABLE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);
  logic [N_CH-1:0] fire;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .clean  (clean_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .fire   (fire[i])
    );
  end

  // Registered from the per-channel fire terms so it lines up with rise/fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_change <= 1'b0;
    else          any_change <= |fire;
  end
endmodule

// File: tb/tb_abc_input_conditioner.sv
// Directed plus randomized checks of the input conditioner against a
// run-length behavioural model.
module tb_abc_input_conditioner;
  import abc_cond_pkg::*;
  localparam int N = 3;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] raw_in = '1;
  logic [N-1:0] clean_out, rise, fall;
  logic         any_change;

  abc_input_conditioner #(.N_CH(N), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  always #4 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a channel's clean level flips once S consecutive synchronised
  // samples disagree with it; the synchroniser is a two-sample delay.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0;
  logic         m_any = 1'b0;
  int           m_run[N];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_clean <= '0; m_rise <= '0; m_fall <= '0; m_any <= 1'b0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin : step
      logic [N-1:0] nc, nr, nf;
      int run;
      nc = m_clean; nr = '0; nf = '0;
      for (int i = 0; i < N; i++) begin
        run = (m_s2[i] != m_clean[i]) ? m_run[i] + 1 : 0;
        if (run == S) begin
          nc[i] = m_s2[i];
          nr[i] = m_s2[i];
          nf[i] = ~m_s2[i];
          run = 0;
        end
        m_run[i] <= run;
      end
      m_clean <= nc; m_rise <= nr; m_fall <= nf; m_any <= |(nr | nf);
      m_s2 <= m_s1; m_s1 <= raw_in;
    end
  end

  always @(negedge clk)
    chk("cycle", 16'({clean_out, rise, fall, any_change}),
                 16'({m_clean, m_rise, m_fall, m_any}));

  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [N-1:0] v);
    raw_in = v;
    wait_edges(10);
  endtask

  logic bad;

  initial begin
    // Reset with all raw lines high
    #2 chk("reset_outs", 16'({clean_out, rise, fall, any_change}), 16'h0);
    #6 chk("reset_outs_after_edge", 16'({clean_out, rise, fall, any_change}), 16'h0);
    #2 reset_n = 1'b1;
    wait_edges(5); chk("post_reset_edge5", 16'(clean_out), 16'h0);
    wait_edges(1); chk("post_reset_edge6", 16'(clean_out), 16'h7);
    chk("post_reset_rise", 16'({rise, any_change}), 16'b1111);
    wait_edges(1); chk("post_reset_rise_off", 16'({rise, any_change}), 16'h0);

    // Clean rising edge on a
    settle(3'b000);
    @(posedge clk); #1 raw_in[CH_A] = 1'b1;
    wait_edges(5); chk("rise_a_edge5", 16'(clean_out), 16'h0);
    wait_edges(1); chk("rise_a_clean", 16'(clean_out), 16'h4);
    chk("rise_a_strobes", 16'({rise, fall, any_change}), 16'b100_000_1);
    wait_edges(1); chk("rise_a_off", 16'({rise, fall, any_change}), 16'h0);

    // b and c drop together
    settle(3'b111);
    @(posedge clk); #1 raw_in = 3'b100;
    wait_edges(5); chk("fall_bc_edge5", 16'(clean_out), 16'h7);
    wait_edges(1); chk("fall_bc_clean", 16'(clean_out), 16'h4);
    chk("fall_bc_strobes", 16'({rise, fall, any_change}), 16'b000_011_1);

    // Two-period glitch on b
    settle(3'b000);
    @(posedge clk); #1 raw_in[CH_B] = 1'b1;
    wait_edges(2); raw_in[CH_B] = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wait_edges(1);
      if (clean_out != 0 || rise != 0 || fall != 0 || any_change) bad = 1'b1;
    end
    chk("glitch_b", 16'(bad), 16'h0);

    // Reset pulse in the middle of c's window
    settle(3'b100);
    @(posedge clk); #1 raw_in = 3'b101;
    wait_edges(3);
    #1 reset_n = 1'b0;
    #1 chk("mid_reset_outs", 16'({clean_out, rise, fall, any_change}), 16'h0);
    #2 reset_n = 1'b1;
    wait_edges(5); chk("mid_reset_edge5", 16'(clean_out), 16'h0);
    wait_edges(1); chk("mid_reset_edge6", 16'(clean_out), 16'h5);
    chk("mid_reset_rise", 16'(rise), 16'h5);

    // a chatters every clock
    settle(3'b101);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1 raw_in[CH_A] = ~raw_in[CH_A];
      if (!clean_out[CH_A] || rise[CH_A] || fall[CH_A]) bad = 1'b1;
    end
    chk("chatter_a", 16'(bad), 16'h0);
    settle(3'b101);

    // Random traffic with occasional asynchronous reset pulses
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #($urandom_range(1, 3));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) raw_in[i] = ~raw_in[i];
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    wait_edges(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
